btn_debounce: RTL and testbench



---
 rtl/debounce_pkg.sv | 30 +++
 rtl/std_sync.sv | 27 ++
 rtl/btn_debounce.sv | 180 ++++++++++++++++++
 tb/tb_btn_debounce.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button / switch debouncer.
// Holds the qualifier state encoding, the glitch counter width and a
// saturating increment helper used by the glitch counter.
package debounce_pkg;

  // Qualifier states: STABLE while s matches level, QUAL while a change is
  // being timed.
  typedef enum logic [0:0] {
    STABLE = 1'b0,
    QUAL   = 1'b1
  } state_e;

  // Width of the rejected-change counter presented on glitch_cnt.
  localparam int GLITCH_W = 8;

  // All-ones value at which the glitch counter stops counting.
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

  // Increment by one, holding at GLITCH_MAX instead of wrapping to zero.
  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] value);
    logic [GLITCH_W-1:0] result;
    if (value == GLITCH_MAX) begin
      result = value;
    end else begin
      result = value + {{(GLITCH_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/std_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// The first flop may go metastable; the remaining STAGES-1 flops give it
// time to resolve before the value is used in the clk domain.
module std_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic arst_n,
  input  logic d,
  output logic q
);

  // Chain of capture flops, oldest sample in the MSB.
  logic [STAGES-1:0] sync_r;

  // Shift the raw input one stage further on every clock; clear on reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Debouncer and edge detector for one bouncy asynchronous input.
//
// The raw pin is synchronized, then a two-state qualifier decides when the
// synchronized value s has disagreed with the debounced level for
// DEBOUNCE_CYCLES consecutive samples. Only then does level follow s, and
// the same clock edge produces a one-cycle rise or fall strobe. A change
// that collapses before it is qualified is counted as a glitch in a
// saturating counter that glitch_clr resets.
//
// Every output comes straight from a flop, so downstream logic sees no
// combinational path from din_async or glitch_clr.
module btn_debounce
  import debounce_pkg::*;
#(
  parameter int STAGES          = 2,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                din_async,
  input  logic                glitch_clr,
  output logic                level,
  output logic                rise,
  output logic                fall,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  // ------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ------------------------------------------------------------------
  localparam longint CNT_LIMIT = longint'(64'd1) << CNT_W;

  if (STAGES < 2) begin : g_bad_stages
    $error("btn_debounce: STAGES must be at least 2");
  end

  if ((DEBOUNCE_CYCLES < 1) || (longint'(DEBOUNCE_CYCLES) >= CNT_LIMIT)) begin : g_bad_cycles
    $error("btn_debounce: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_W-1");
  end

  // ------------------------------------------------------------------
  // Constants
  // ------------------------------------------------------------------
  // A single qualifying sample means no QUAL state is needed at all.
  localparam bit               SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);
  // Count value reached on the sample just before the one that qualifies.
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

  // ------------------------------------------------------------------
  // Synchronizer
  // ------------------------------------------------------------------
  // s is the only view of din_async the qualifier is allowed to use.
  logic s;

  std_sync #(
    .STAGES (STAGES)
  ) u_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .d      (din_async),
    .q      (s)
  );

  // ------------------------------------------------------------------
  // State and next-state signals
  // ------------------------------------------------------------------
  state_e              state_r,  state_s;
  logic [CNT_W-1:0]    cnt_r,    cnt_s;
  logic                level_r,  level_s;
  logic                rise_r,   rise_s;
  logic                fall_r,   fall_s;
  logic                busy_r,   busy_s;
  logic [GLITCH_W-1:0] glitch_r, glitch_s;
  logic                abort_s;

  // Register the qualifier state, counter, debounced level and all outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r  <= STABLE;
      cnt_r    <= '0;
      level_r  <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      busy_r   <= 1'b0;
      glitch_r <= '0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      level_r  <= level_s;
      rise_r   <= rise_s;
      fall_r   <= fall_s;
      busy_r   <= busy_s;
      glitch_r <= glitch_s;
    end
  end

  // Decide the next qualifier state, count, level and edge strobes.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    level_s = level_r;
    rise_s  = 1'b0;
    fall_s  = 1'b0;
    abort_s = 1'b0;

    case (state_r)
      STABLE: begin
        if (s != level_r) begin
          if (SINGLE_SAMPLE) begin
            // One differing sample is already enough: accept at once.
            level_s = s;
            rise_s  = s;
            fall_s  = ~s;
            cnt_s   = '0;
            state_s = STABLE;
          end else begin
            // First differing sample counts as sample number one.
            cnt_s   = CNT_ONE;
            state_s = QUAL;
          end
        end else begin
          cnt_s   = '0;
          state_s = STABLE;
        end
      end

      QUAL: begin
        if (s == level_r) begin
          // The change collapsed before it was qualified: it was a glitch.
          abort_s = 1'b1;
          cnt_s   = '0;
          state_s = STABLE;
        end else if (cnt_r == CNT_LAST) begin
          // DEBOUNCE_CYCLES consecutive differing samples: accept.
          level_s = s;
          rise_s  = s;
          fall_s  = ~s;
          cnt_s   = '0;
          state_s = STABLE;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
          state_s = QUAL;
        end
      end

      default: begin
        cnt_s   = '0;
        state_s = STABLE;
      end
    endcase

    // busy is registered from the next state so it lines up with state_r.
    busy_s = (state_s == QUAL);
  end

  // Next value of the glitch counter; a clear wins over a same-cycle abort.
  always_comb begin
    glitch_s = glitch_r;
    if (glitch_clr) begin
      glitch_s = '0;
    end else if (abort_s) begin
      glitch_s = sat_inc(glitch_r);
    end else begin
      glitch_s = glitch_r;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign level      = level_r;
  assign rise       = rise_r;
  assign fall       = fall_r;
  assign busy       = busy_r;
  assign glitch_cnt = glitch_r;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce (STAGES = 2, DEBOUNCE_CYCLES = 4).
// A reference model on the rising edge predicts every output and queues it;
// a monitor on the falling edge pops and compares. Directed scenarios add
// constant checks on top of the model.
module tb_btn_debounce;

  localparam int ST = 2;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic       din_async = 1'b0;
  logic       glitch_clr = 1'b0;
  logic       level, rise, fall, busy;
  logic [7:0] glitch_cnt;

  btn_debounce #(
    .STAGES          (ST),
    .CNT_W           (16),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .din_async  (din_async),
    .glitch_clr (glitch_clr),
    .level      (level),
    .rise       (rise),
    .fall       (fall),
    .busy       (busy),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       level;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] gc;
  } out_t;

  out_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   rise_seen = 0;
  int   fall_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: s is din delayed by ST edges; level flips once the last
  // DB samples all differ from it; a differing run ending in an agreeing
  // sample is a glitch.
  logic dq[$];
  logic sh[$];
  logic m_level = 1'b0;
  int   m_gc = 0;

  always @(posedge clk) begin : model
    out_t e;
    logic x;
    logic prev;
    bit   have_prev;
    bit   all_diff;
    bit   abort;
    e = '0;
    if (!arst_n) begin
      dq = {};
      for (int i = 0; i < ST; i++) dq.push_back(1'b0);
      sh = {};
      m_level = 1'b0;
      m_gc = 0;
    end else begin
      dq.push_back(din_async);
      x = dq.pop_front();
      have_prev = (sh.size() > 0);
      prev = have_prev ? sh[sh.size()-1] : 1'b0;
      sh.push_back(x);
      if (sh.size() > DB) void'(sh.pop_front());
      abort = have_prev && (x == m_level) && (prev != m_level);
      all_diff = (sh.size() == DB);
      foreach (sh[k]) if (sh[k] == m_level) all_diff = 1'b0;
      if (all_diff) begin
        e.rise = x;
        e.fall = ~x;
        m_level = x;
      end
      if (glitch_clr) m_gc = 0;
      else if (abort && m_gc < 255) m_gc = m_gc + 1;
      e.level = m_level;
      e.busy = (x != m_level);
      e.gc = 8'(m_gc);
    end
    sb.push_back(e);
  end

  // Monitor: compare DUT outputs with the predicted values each cycle.
  always @(negedge clk) begin : monitor
    out_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("level", level, e.level);
      chk("rise", rise, e.rise);
      chk("fall", fall, e.fall);
      chk("busy", busy, e.busy);
      chk("glitch_cnt", glitch_cnt, e.gc);
      if (rise) rise_seen++;
      if (fall) fall_seen++;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin : stim
    int r0;
    int f0;
    int len;

    // 1. Reset values and quiet period.
    #2 arst_n = 1'b0;
    tick(3);
    arst_n = 1'b1;
    tick(20);
    chk("t1_level", level, 0);
    chk("t1_busy", busy, 0);
    chk("t1_glitch", glitch_cnt, 0);
    chk("t1_rises", rise_seen, 0);
    chk("t1_falls", fall_seen, 0);

    // 2. Clean rise: busy from e3, level and rise at e6.
    din_async = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("t2_busy", busy, (i >= 3 && i <= 5) ? 1 : 0);
      chk("t2_level", level, (i >= 6) ? 1 : 0);
      chk("t2_rise", rise, (i == 6) ? 1 : 0);
      chk("t2_fall", fall, 0);
      #1;
    end
    chk("t2_glitch", glitch_cnt, 0);

    // Return to low so the next scenario starts from level 0.
    din_async = 1'b0;
    tick(10);
    chk("t2_back_low", level, 0);

    // 3. Short glitch: two high cycles only.
    r0 = rise_seen;
    f0 = fall_seen;
    din_async = 1'b1;
    tick(2);
    din_async = 1'b0;
    tick(10);
    chk("t3_level", level, 0);
    chk("t3_pulses", (rise_seen - r0) + (fall_seen - f0), 0);
    chk("t3_glitch", glitch_cnt, 1);

    // 4. Bounce then settle high.
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    r0 = rise_seen;
    for (int i = 0; i < 5; i++) begin
      din_async = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick(1);
    end
    tick(12);
    chk("t4_rises", rise_seen - r0, 1);
    chk("t4_level", level, 1);
    chk("t4_glitch", glitch_cnt, 2);

    din_async = 1'b0;
    tick(10);

    // 5. Saturate the glitch counter, then clear on an abort cycle.
    for (int i = 0; i < 300; i++) begin
      din_async = 1'b1;
      tick(1);
      din_async = 1'b0;
      tick(1);
    end
    tick(4);
    chk("t5_saturated", glitch_cnt, 255);
    din_async = 1'b1;
    tick(1);
    din_async = 1'b0;
    tick(2);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    chk("t5_cleared", glitch_cnt, 0);
    tick(4);

    // 6. Reset during qualification with din held high.
    din_async = 1'b1;
    tick(4);
    chk("t6_busy_before_rst", busy, 1);
    r0 = rise_seen;
    arst_n = 1'b0;
    tick(3);
    chk("t6_no_pulse_in_rst", rise_seen - r0, 0);
    arst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("t6_rise", rise, (i == 6) ? 1 : 0);
      #1;
    end
    chk("t6_level", level, 1);

    // Randomized segments with occasional clears.
    for (int seg = 0; seg < 80; seg++) begin
      din_async = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        glitch_clr = ($urandom_range(0, 15) == 0);
        tick(1);
      end
    end
    glitch_clr = 1'b0;
    tick(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
